fm_eg: RTL

Per-operator envelope generator for the FM synthesizer. Once per sample tick it scans all operators by driving `op_sel` into the operator-attribute table and consuming that table's per-operator attribute outputs. It keeps per-operator envelope state internally and emits one total attenuation value per operator, in order, to the downstream operator/phase stage.

---
 rtl/fm_eg.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/fm_eg.sv
// fm_eg -- per-operator envelope generator for the FM synthesizer.
//
// Each accepted sample_tick starts a scan of NUM_OPS operators, one per
// clock. The operator index is driven on op_sel; the attribute table answers
// combinationally on the op_* inputs in the same cycle. The envelope state of
// that operator is read, advanced and written back at the clock edge, and
// its total attenuation appears on eg_atten one cycle later with eg_valid.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   sample_tick         one-cycle pulse that starts a scan (ignored while busy)
//   op_sel      [5:0]   operator index presented to the attribute table
//   op_egt, op_ksr      sustain-hold, key-scale-rate
//   op_ksl      [1:0]   key-scale level
//   op_tl       [5:0]   total level
//   op_ar/dr/sl/rr      attack, decay, sustain level, release (4 bits each)
//   op_kon              channel key-on
//   op_block    [2:0]   octave
//   op_fnum_msb         F-number MSB
//   busy                a scan is in progress
//   eg_valid            eg_op / eg_atten valid this cycle
//   eg_op       [5:0]   operator index of the result
//   eg_atten    [8:0]   total attenuation, 0 = loudest, 511 = silent
module fm_eg #(
  parameter int NUM_OPS = 36
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_tick,
  output logic [5:0] op_sel,
  input  logic       op_egt,
  input  logic       op_ksr,
  input  logic [1:0] op_ksl,
  input  logic [5:0] op_tl,
  input  logic [3:0] op_ar,
  input  logic [3:0] op_dr,
  input  logic [3:0] op_sl,
  input  logic [3:0] op_rr,
  input  logic       op_kon,
  input  logic [2:0] op_block,
  input  logic       op_fnum_msb,
  output logic       busy,
  output logic       eg_valid,
  output logic [5:0] eg_op,
  output logic [8:0] eg_atten
);

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY   = 2'd1,
    SUSTAIN = 2'd2,
    RELEASE = 2'd3
  } phase_t;

  typedef struct packed {
    phase_t     phase;
    logic [8:0] atten;
    logic       kon_prev;
  } op_state_t;

  localparam logic [5:0] LAST_OP = 6'(NUM_OPS - 1);

  op_state_t   state_q [NUM_OPS];
  logic [14:0] eg_counter;
  // Counter value sampled at tick acceptance; rate gating for the whole scan
  // uses the pre-increment value.
  logic [10:0] scan_cnt;

  // Effective rate: min(63, 4*R + offset), with R = 0 always giving 0.
  function automatic logic [5:0] eff_rate(input logic [3:0] r,
                                          input logic [3:0] kcode,
                                          input logic       ksr);
    logic [3:0] ofs;
    logic [6:0] sum;
    ofs = ksr ? kcode : {2'b00, kcode[3:2]};
    sum = {1'b0, r, 2'b00} + {3'b000, ofs};
    if (r == 4'd0)
      return 6'd0;
    else if (sum > 7'd63)
      return 6'd63;
    else
      return sum[5:0];
  endfunction

  // Step size for one tick; only rate[5:2] matters. Slow rates step by one
  // when the low counter bits are all zero, fast rates step every tick.
  function automatic logic [4:0] calc_inc(input logic [5:0]  rate,
                                          input logic [10:0] cnt);
    logic [3:0]  hi;
    logic [11:0] mask;
    hi = rate[5:2];
    if (rate == 6'd0) begin
      return 5'd0;
    end else if (hi < 4'd11) begin
      mask = (12'd1 << (4'd11 - hi)) - 12'd1;
      return ((cnt & mask[10:0]) == 11'd0) ? 5'd1 : 5'd0;
    end else begin
      return 5'd1 << (hi - 4'd11);
    end
  endfunction

  function automatic logic [8:0] sat_add(input logic [8:0] a,
                                         input logic [4:0] inc);
    logic [9:0] s;
    s = {1'b0, a} + {5'b00000, inc};
    return s[9] ? 9'd511 : s[8:0];
  endfunction

  op_state_t  cur;
  op_state_t  nxt;
  logic [3:0] kcode;
  logic [5:0] ar_rate, dr_rate, rr_rate;
  logic [4:0] inc_a, inc_d, inc_r;
  logic [6:0] att_step;
  logic [10:0] att_dec;
  logic [8:0] target;
  logic [5:0] blk8;
  logic [5:0] ksl_term;
  logic [10:0] total;

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    cur      = state_q[op_sel];
    nxt      = cur;
    kcode    = {op_block, op_fnum_msb};
    ar_rate  = eff_rate(op_ar, kcode, op_ksr);
    dr_rate  = eff_rate(op_dr, kcode, op_ksr);
    rr_rate  = eff_rate(op_rr, kcode, op_ksr);
    inc_a    = calc_inc(ar_rate, scan_cnt);
    inc_d    = calc_inc(dr_rate, scan_cnt);
    inc_r    = calc_inc(rr_rate, scan_cnt);
    att_step = {1'b0, cur.atten[8:3]} + 7'd1;
    att_dec  = {4'b0000, att_step} * {6'b000000, inc_a};
    target   = (op_sl == 4'd15) ? 9'd496 : {1'b0, op_sl, 4'b0000};
    blk8     = {op_block, 3'b000};
    ksl_term = 6'd0;
    total    = 11'd0;

    nxt.kon_prev = op_kon;

    if (op_kon && !cur.kon_prev) begin
      // Key-on: very fast attack rates skip straight to the decay phase.
      if (ar_rate >= 6'd60) begin
        nxt.atten = 9'd0;
        nxt.phase = DECAY;
      end else begin
        nxt.phase = ATTACK;
      end
    end else if (!op_kon && cur.kon_prev) begin
      nxt.phase = RELEASE;
    end else begin
      unique case (cur.phase)
        ATTACK: begin
          if (ar_rate >= 6'd60)
            nxt.atten = 9'd0;
          else if (att_dec >= {2'b00, cur.atten})
            nxt.atten = 9'd0;
          else
            nxt.atten = cur.atten - att_dec[8:0];
          if (nxt.atten == 9'd0)
            nxt.phase = DECAY;
        end
        DECAY: begin
          nxt.atten = sat_add(cur.atten, inc_d);
          if (nxt.atten >= target)
            nxt.phase = SUSTAIN;
        end
        SUSTAIN: begin
          if (!op_egt)
            nxt.atten = sat_add(cur.atten, inc_r);
        end
        RELEASE: begin
          nxt.atten = sat_add(cur.atten, inc_r);
        end
        default: nxt = cur;
      endcase
    end

    unique case (op_ksl)
      2'd1:    ksl_term = blk8 >> 1;
      2'd2:    ksl_term = blk8 >> 2;
      2'd3:    ksl_term = blk8;
      default: ksl_term = 6'd0;
    endcase

    total = {2'b00, nxt.atten} + {3'b000, op_tl, 2'b00} + {5'b00000, ksl_term};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_sel     <= 6'd0;
      busy       <= 1'b0;
      eg_valid   <= 1'b0;
      eg_op      <= 6'd0;
      eg_atten   <= 9'd0;
      eg_counter <= 15'd0;
      scan_cnt   <= 11'd0;
      // NOTE: the state array is held in flops with an async reset because
      // every operator must come up silent in RELEASE; a RAM could not be
      // cleared in one cycle.
      for (int i = 0; i < NUM_OPS; i++)
        state_q[i] <= '{phase: RELEASE, atten: 9'd511, kon_prev: 1'b0};
    end else begin
      // NOTE: non-blocking assignments throughout so every register sees the
      // pre-edge values of the others.
      eg_valid <= busy;
      if (busy) begin
        state_q[op_sel] <= nxt;
        eg_op           <= op_sel;
        eg_atten        <= (total > 11'd511) ? 9'd511 : total[8:0];
        if (op_sel == LAST_OP) begin
          busy   <= 1'b0;
          op_sel <= 6'd0;
        end else begin
          op_sel <= op_sel + 6'd1;
        end
      end else if (sample_tick) begin
        busy       <= 1'b1;
        op_sel     <= 6'd0;
        scan_cnt   <= eg_counter[10:0];
        eg_counter <= eg_counter + 15'd1;
      end
    end
  end

endmodule
